comp: RTL and testbench

COMP -- requirements
Module: comp

---
 rtl/comp_pkg.sv | 17 +
 rtl/comp_core.sv | 19 +
 rtl/comp.sv | 77 +++++++
 tb/tb_comp.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared constants and types for the unsigned comparator block.
package comp_pkg;

    // Default operand width in bits.
    localparam int WIDTH_DEF = 8;

    // Default width of the less-than event counter.
    localparam int CNT_W_DEF = 16;

    // Result of one compare; exactly one field is set for binary operands.
    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_flags_t;

endpackage

// File: rtl/comp_core.sv
// Purely combinational unsigned magnitude compare of two operands.
module comp_core #(
    parameter int WIDTH = comp_pkg::WIDTH_DEF
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    // Three mutually exclusive relations; X/Z on the operands propagates unmasked.
    always_comb begin
        lt = (A < B);
        eq = (A == B);
        gt = (A > B);
    end

endmodule

// File: rtl/comp.sv
// Unsigned comparator with registered less-than flag, rise pulse and a
// saturating count of cycles in which A < B was sampled.
module comp
    import comp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Y,
    output logic             EQ,
    output logic             GT,
    output logic             Y_q,
    output logic             y_rise,
    output logic [CNT_W-1:0] lt_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    cmp_flags_t       flags;
    logic             y_q_reg;
    logic             y_rise_reg;
    logic [CNT_W-1:0] lt_count_reg;
    logic [CNT_W-1:0] lt_count_next;

    comp_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A  (A),
        .B  (B),
        .lt (flags.lt),
        .eq (flags.eq),
        .gt (flags.gt)
    );

    // Flags go straight out; reset deliberately has no influence on them.
    always_comb begin
        Y  = flags.lt;
        EQ = flags.eq;
        GT = flags.gt;
    end

    // Counter advances on every sampled less-than and parks at all-ones.
    always_comb begin
        lt_count_next = lt_count_reg;
        if (flags.lt && (lt_count_reg != CNT_MAX)) begin
            lt_count_next = lt_count_reg + CNT_ONE;
        end
    end

    // Registered state; reset takes priority over a simultaneous less-than.
    // The rise pulse is registered alongside Y_q so it is high exactly in the
    // first cycle that Y_q reads 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_reg      <= 1'b0;
            y_rise_reg   <= 1'b0;
            lt_count_reg <= '0;
        end else begin
            y_q_reg      <= flags.lt;
            y_rise_reg   <= flags.lt & ~y_q_reg;
            lt_count_reg <= lt_count_next;
        end
    end

    // Expose registered state.
    always_comb begin
        Y_q      = y_q_reg;
        y_rise   = y_rise_reg;
        lt_count = lt_count_reg;
    end

endmodule

// File: tb/tb_comp.sv
// Self-checking bench for comp: directed corner cases, reset behaviour,
// counter saturation on a narrow instance and randomized compares.
module tb_comp;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic [7:0]  A;
    logic [7:0]  B;

    logic        Y, EQ, GT, Y_q, y_rise;
    logic [15:0] lt_count;
    logic        Y4, EQ4, GT4, Y_q4, y_rise4;
    logic [3:0]  lt_count4;

    int passed;
    int total;

    // Reference model state (plain integers, updated per clock edge).
    int yq_m;
    int rise_m;
    int cnt16_m;
    int cnt4_m;

    comp dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Y        (Y),
        .EQ       (EQ),
        .GT       (GT),
        .Y_q      (Y_q),
        .y_rise   (y_rise),
        .lt_count (lt_count)
    );

    comp #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut4 (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Y        (Y4),
        .EQ       (EQ4),
        .GT       (GT4),
        .Y_q      (Y_q4),
        .y_rise   (y_rise4),
        .lt_count (lt_count4)
    );

    // Clock only toggles once enabled, so the first checks run clockless.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Apply operands, let them settle, compare flags with integer arithmetic.
    task automatic combo(input int a, input int b, input int settle);
        int lt, eq, gt;
        A = a[7:0];
        B = b[7:0];
        #(settle);
        lt = (a < b) ? 1 : 0;
        eq = (a == b) ? 1 : 0;
        gt = (a > b) ? 1 : 0;
        check("Y", 32'(Y), 32'(lt));
        check("EQ", 32'(EQ), 32'(eq));
        check("GT", 32'(GT), 32'(gt));
        check("onehot", 32'(Y) + 32'(EQ) + 32'(GT), 32'd1);
    endtask

    // One clock edge: predict from the current inputs, then compare.
    task automatic step(input bit verbose);
        int lt;
        lt = (int'(A) < int'(B)) ? 1 : 0;
        if (rst) begin
            yq_m = 0; rise_m = 0; cnt16_m = 0; cnt4_m = 0;
        end else begin
            rise_m  = (lt == 1 && yq_m == 0) ? 1 : 0;
            yq_m    = lt;
            cnt16_m = (lt == 1 && cnt16_m < 65535) ? cnt16_m + 1 : cnt16_m;
            cnt4_m  = (lt == 1 && cnt4_m < 15) ? cnt4_m + 1 : cnt4_m;
        end
        @(posedge clk);
        #1;
        check("Y_q", 32'(Y_q), 32'(yq_m));
        check("y_rise", 32'(y_rise), 32'(rise_m));
        check("lt_count", 32'(lt_count), 32'(cnt16_m));
        check("Y_q4", 32'(Y_q4), 32'(yq_m));
        check("y_rise4", 32'(y_rise4), 32'(rise_m));
        check("lt_count4", 32'(lt_count4), 32'(cnt4_m));
        if (verbose)
            $display("edge rst=%0d A=%0d B=%0d Y_q=%0d y_rise=%0d lt_count=%0d lt_count4=%0d",
                     rst, A, B, Y_q, y_rise, lt_count, lt_count4);
    endtask

    initial begin
        passed = 0; total = 0;
        yq_m = 0; rise_m = 0; cnt16_m = 0; cnt4_m = 0;
        clk_en = 1'b0;
        rst = 1'b0;
        A = '0;
        B = '0;

        // Clockless combinational corners.
        combo(1, 2, 10);
        combo(3, 2, 10);
        combo(8, 8, 10);
        combo(255, 1, 10);
        combo(0, 255, 10);
        combo(255, 0, 10);
        combo(255, 255, 10);
        $display("combinational corner compares done");

        // Reset for two edges while Y=1: reset must win, flags stay live.
        clk_en = 1'b1;
        A = 8'd1; B = 8'd2;
        rst = 1'b1;
        step(1'b1);
        check("Y_in_reset", 32'(Y), 32'd1);
        step(1'b1);
        A = 8'd9; B = 8'd4;
        #1;
        check("GT_in_reset", 32'(GT), 32'd1);
        A = 8'd1; B = 8'd2;
        rst = 1'b0;

        // Hold A<B for five edges: pulse once, count to five.
        for (int i = 0; i < 5; i++) step(1'b1);
        check("lt_count_after5", 32'(lt_count), 32'd5);

        // Keep holding for saturation of the 4-bit counter.
        for (int i = 0; i < 20; i++) step(1'b0);
        check("lt_count4_sat", 32'(lt_count4), 32'd15);
        check("lt_count_25", 32'(lt_count), 32'd25);

        // Single reset edge mid-count with Y=1.
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        check("lt_count4_clr", 32'(lt_count4), 32'd0);
        step(1'b1);

        // Randomized sequential run with occasional resets.
        for (int i = 0; i < 400; i++) begin
            A = 8'($urandom_range(0, 255));
            B = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) B = A;
            rst = ($urandom_range(0, 29) == 0);
            step(1'b0);
        end
        rst = 1'b0;
        $display("random sequential run done");

        // Randomized combinational sweep.
        for (int i = 0; i < 10000; i++) begin
            combo(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1);
        end
        $display("random combinational sweep done");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
